// File: rtl/mips_core_ctrl_exec_if.sv
// Signal bundle between the single-cycle MIPS top level and its control/execute core:
// PC load path, fetched instruction, ALU operands/results and decoded control strobes.
interface mips_core_ctrl_exec_if;
  logic        pc_en;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic [31:0] alu_r1;
  logic [31:0] alu_r2;
  logic        alu_eq;
  logic [3:0]  aluop;
  logic        reg_dst;
  logic        reg_we;
  logic        branch;
  logic        jump;
  logic        mem_we;
  logic        mem_to_reg;
  logic        alu_src;
  logic        shift;
  logic        equ;
  logic        jump_reg;
  logic        jal;
  logic        usign;
  logic        sys;
  logic        shift_var;
  logic        load_imm;
  logic        store_half;

  modport master (
    output pc_en, pc_next, instr, alu_x, alu_y,
    input  pc, alu_r1, alu_r2, alu_eq, aluop,
    input  reg_dst, reg_we, branch, jump, mem_we, mem_to_reg, alu_src, shift,
    input  equ, jump_reg, jal, usign, sys, shift_var, load_imm, store_half
  );

  modport slave (
    input  pc_en, pc_next, instr, alu_x, alu_y,
    output pc, alu_r1, alu_r2, alu_eq, aluop,
    output reg_dst, reg_we, branch, jump, mem_we, mem_to_reg, alu_src, shift,
    output equ, jump_reg, jal, usign, sys, shift_var, load_imm, store_half
  );
endinterface

// File: rtl/mips_core_ctrl_exec.sv
// Single-cycle MIPS control/execute core: falling-edge PC register, combinational
// instruction decoder and 32-bit ALU driven by the decoded aluop.
module mips_core_ctrl_exec (
  input  logic                     clk,
  input  logic                     rst_n,
  mips_core_ctrl_exec_if.slave     bus
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_instr_bits;

  assign op                = bus.instr[31:26];
  assign funct             = bus.instr[5:0];
  assign unused_instr_bits = ^bus.instr[25:6];

  // PC register: loads on the falling edge so the next instruction settles in the high phase
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)          bus.pc <= '0;
    else if (bus.pc_en)  bus.pc <= bus.pc_next;
  end

  always_comb begin
    bus.reg_dst    = 1'b0;
    bus.reg_we     = 1'b0;
    bus.branch     = 1'b0;
    bus.jump       = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src    = 1'b0;
    bus.shift      = 1'b0;
    bus.equ        = 1'b0;
    bus.jump_reg   = 1'b0;
    bus.jal        = 1'b0;
    bus.usign      = 1'b0;
    bus.sys        = 1'b0;
    bus.shift_var  = 1'b0;
    bus.load_imm   = 1'b0;
    bus.store_half = 1'b0;
    bus.aluop      = 4'd5;
    case (op)
      6'h00: begin
        bus.reg_dst = 1'b1;
        bus.reg_we  = 1'b1;
        case (funct)
          6'h00: begin bus.shift = 1'b1; bus.aluop = 4'd0; end
          6'h03: begin bus.shift = 1'b1; bus.aluop = 4'd1; end
          6'h02: begin bus.shift = 1'b1; bus.aluop = 4'd2; end
          6'h04: begin bus.shift = 1'b1; bus.shift_var = 1'b1; bus.aluop = 4'd0; end
          6'h07: begin bus.shift = 1'b1; bus.shift_var = 1'b1; bus.aluop = 4'd1; end
          6'h06: begin bus.shift = 1'b1; bus.shift_var = 1'b1; bus.aluop = 4'd2; end
          6'h20, 6'h21: bus.aluop = 4'd5;
          6'h22, 6'h23: bus.aluop = 4'd6;
          6'h24: bus.aluop = 4'd7;
          6'h25: bus.aluop = 4'd8;
          6'h26: bus.aluop = 4'd9;
          6'h27: bus.aluop = 4'd10;
          6'h2A: bus.aluop = 4'd11;
          6'h2B: bus.aluop = 4'd12;
          6'h08: begin bus.jump_reg = 1'b1; bus.reg_we = 1'b0; bus.reg_dst = 1'b0; end
          6'h0C: begin bus.sys = 1'b1; bus.reg_we = 1'b0; bus.reg_dst = 1'b0; end
          default: begin bus.reg_we = 1'b0; bus.reg_dst = 1'b0; end
        endcase
      end
      6'h08, 6'h09: begin bus.alu_src = 1'b1; bus.reg_we = 1'b1; bus.aluop = 4'd5; end
      6'h0A: begin bus.alu_src = 1'b1; bus.reg_we = 1'b1; bus.aluop = 4'd11; end
      6'h0B: begin bus.alu_src = 1'b1; bus.reg_we = 1'b1; bus.aluop = 4'd12; end
      6'h0C: begin bus.alu_src = 1'b1; bus.reg_we = 1'b1; bus.usign = 1'b1; bus.aluop = 4'd7; end
      6'h0D: begin bus.alu_src = 1'b1; bus.reg_we = 1'b1; bus.usign = 1'b1; bus.aluop = 4'd8; end
      6'h0E: begin bus.alu_src = 1'b1; bus.reg_we = 1'b1; bus.usign = 1'b1; bus.aluop = 4'd9; end
      6'h0F: begin bus.load_imm = 1'b1; bus.reg_we = 1'b1; end
      6'h23: begin bus.alu_src = 1'b1; bus.mem_to_reg = 1'b1; bus.reg_we = 1'b1; end
      6'h2B: begin bus.alu_src = 1'b1; bus.mem_we = 1'b1; end
      6'h29: begin bus.alu_src = 1'b1; bus.mem_we = 1'b1; bus.store_half = 1'b1; end
      6'h04: begin bus.branch = 1'b1; bus.equ = 1'b1; bus.aluop = 4'd6; end
      6'h05: begin bus.branch = 1'b1; bus.aluop = 4'd6; end
      6'h02: bus.jump = 1'b1;
      6'h03: begin bus.jump = 1'b1; bus.jal = 1'b1; bus.reg_we = 1'b1; end
      default: ;
    endcase
  end

  logic signed [31:0] xs;
  logic signed [31:0] ys;
  logic signed [63:0] xw;
  logic signed [63:0] yw;
  logic signed [63:0] prod;
  logic signed [31:0] quo;
  logic signed [31:0] rem;
  logic        [4:0]  shamt;

  assign xs    = bus.alu_x;
  assign ys    = bus.alu_y;
  assign xw    = {{32{bus.alu_x[31]}}, bus.alu_x};
  assign yw    = {{32{bus.alu_y[31]}}, bus.alu_y};
  assign prod  = xw * yw;
  assign shamt = bus.alu_y[4:0];

  // Divide-by-zero and the INT_MIN/-1 overflow are pinned to defined results
  always_comb begin
    if (ys == 32'sd0) begin
      quo = -32'sd1;
      rem = xs;
    end else if (bus.alu_x == 32'h8000_0000 && bus.alu_y == 32'hFFFF_FFFF) begin
      quo = xs;
      rem = 32'sd0;
    end else begin
      quo = xs / ys;
      rem = xs % ys;
    end
  end

  always_comb begin
    bus.alu_r1 = '0;
    bus.alu_r2 = '0;
    case (bus.aluop)
      4'd0:  bus.alu_r1 = bus.alu_x << shamt;
      4'd1:  bus.alu_r1 = xs >>> shamt;
      4'd2:  bus.alu_r1 = bus.alu_x >> shamt;
      4'd3:  begin bus.alu_r1 = prod[31:0]; bus.alu_r2 = prod[63:32]; end
      4'd4:  begin bus.alu_r1 = quo; bus.alu_r2 = rem; end
      4'd5:  bus.alu_r1 = bus.alu_x + bus.alu_y;
      4'd6:  bus.alu_r1 = bus.alu_x - bus.alu_y;
      4'd7:  bus.alu_r1 = bus.alu_x & bus.alu_y;
      4'd8:  bus.alu_r1 = bus.alu_x | bus.alu_y;
      4'd9:  bus.alu_r1 = bus.alu_x ^ bus.alu_y;
      4'd10: bus.alu_r1 = ~(bus.alu_x | bus.alu_y);
      4'd11: bus.alu_r1 = {31'd0, xs < ys};
      4'd12: bus.alu_r1 = {31'd0, bus.alu_x < bus.alu_y};
      default: ;
    endcase
  end

  assign bus.alu_eq = (bus.alu_x == bus.alu_y);

endmodule

// File: tb/tb_mips_core_ctrl_exec.sv
// Bench for mips_core_ctrl_exec: directed PC/ALU/decode steps plus randomized vectors
// compared against a mnemonic-level decoder model and a 64-bit arithmetic ALU model.
module tb_mips_core_ctrl_exec;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [3:0] fop;

  mips_core_ctrl_exec_if bus ();

  mips_core_ctrl_exec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic reg_dst, reg_we, branch, jump, mem_we, mem_to_reg, alu_src, shift;
    logic equ, jump_reg, jal, usign, sys, shift_var, load_imm, store_half;
    logic [3:0] aluop;
  } ctrl_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic string mnem(input logic [31:0] i);
    string m;
    m = "bad";
    case (i[31:26])
      6'h00: case (i[5:0])
        6'h00: m = "sll";  6'h03: m = "sra";  6'h02: m = "srl";
        6'h04: m = "sllv"; 6'h07: m = "srav"; 6'h06: m = "srlv";
        6'h20: m = "add";  6'h21: m = "addu"; 6'h22: m = "sub";  6'h23: m = "subu";
        6'h24: m = "and";  6'h25: m = "or";   6'h26: m = "xor";  6'h27: m = "nor";
        6'h2A: m = "slt";  6'h2B: m = "sltu"; 6'h08: m = "jr";   6'h0C: m = "syscall";
        default: m = "bad";
      endcase
      6'h08: m = "addi"; 6'h09: m = "addiu"; 6'h0A: m = "slti"; 6'h0B: m = "sltiu";
      6'h0C: m = "andi"; 6'h0D: m = "ori";   6'h0E: m = "xori"; 6'h0F: m = "lui";
      6'h23: m = "lw";   6'h2B: m = "sw";    6'h29: m = "sh";   6'h04: m = "beq";
      6'h05: m = "bne";  6'h02: m = "j";     6'h03: m = "jal";
      default: m = "bad";
    endcase
    return m;
  endfunction

  function automatic ctrl_t expect_ctrl(input string m);
    ctrl_t c;
    c = '0;
    c.aluop = 4'd5;
    case (m)
      "sll", "sra", "srl", "sllv", "srav", "srlv": begin
        c.reg_dst = 1; c.reg_we = 1; c.shift = 1;
        c.shift_var = (m.len() == 4);
        c.aluop = (m.substr(1, 2) == "ll") ? 4'd0 : (m.substr(1, 2) == "ra") ? 4'd1 : 4'd2;
      end
      "add", "addu": begin c.reg_dst = 1; c.reg_we = 1; c.aluop = 4'd5; end
      "sub", "subu": begin c.reg_dst = 1; c.reg_we = 1; c.aluop = 4'd6; end
      "and":  begin c.reg_dst = 1; c.reg_we = 1; c.aluop = 4'd7; end
      "or":   begin c.reg_dst = 1; c.reg_we = 1; c.aluop = 4'd8; end
      "xor":  begin c.reg_dst = 1; c.reg_we = 1; c.aluop = 4'd9; end
      "nor":  begin c.reg_dst = 1; c.reg_we = 1; c.aluop = 4'd10; end
      "slt":  begin c.reg_dst = 1; c.reg_we = 1; c.aluop = 4'd11; end
      "sltu": begin c.reg_dst = 1; c.reg_we = 1; c.aluop = 4'd12; end
      "jr":      c.jump_reg = 1;
      "syscall": c.sys = 1;
      "addi", "addiu": begin c.alu_src = 1; c.reg_we = 1; end
      "slti":  begin c.alu_src = 1; c.reg_we = 1; c.aluop = 4'd11; end
      "sltiu": begin c.alu_src = 1; c.reg_we = 1; c.aluop = 4'd12; end
      "andi":  begin c.alu_src = 1; c.reg_we = 1; c.usign = 1; c.aluop = 4'd7; end
      "ori":   begin c.alu_src = 1; c.reg_we = 1; c.usign = 1; c.aluop = 4'd8; end
      "xori":  begin c.alu_src = 1; c.reg_we = 1; c.usign = 1; c.aluop = 4'd9; end
      "lui":   begin c.load_imm = 1; c.reg_we = 1; end
      "lw":    begin c.alu_src = 1; c.mem_to_reg = 1; c.reg_we = 1; end
      "sw":    begin c.alu_src = 1; c.mem_we = 1; end
      "sh":    begin c.alu_src = 1; c.mem_we = 1; c.store_half = 1; end
      "beq":   begin c.branch = 1; c.equ = 1; c.aluop = 4'd6; end
      "bne":   begin c.branch = 1; c.aluop = 4'd6; end
      "j":     c.jump = 1;
      "jal":   begin c.jump = 1; c.jal = 1; c.reg_we = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctrl_t observed_ctrl();
    ctrl_t c;
    c = {bus.reg_dst, bus.reg_we, bus.branch, bus.jump, bus.mem_we, bus.mem_to_reg,
         bus.alu_src, bus.shift, bus.equ, bus.jump_reg, bus.jal, bus.usign, bus.sys,
         bus.shift_var, bus.load_imm, bus.store_half, bus.aluop};
    return c;
  endfunction

  // Reference ALU evaluated on 64-bit sign/zero-extended operands
  task automatic alu_model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] r1, output logic [31:0] r2);
    longint sx, sy, ux, uy;
    logic [63:0] t;
    int sh;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = longint'({32'd0, x}); uy = longint'({32'd0, y});
    sh = int'(y % 32);
    r2 = 32'd0;
    t  = 64'd0;
    case (op)
      4'd0:  t = 64'(ux << sh);
      4'd1:  t = 64'(sx >> sh);
      4'd2:  t = 64'(ux >> sh);
      4'd3:  begin t = 64'(sx * sy); r2 = t[63:32]; end
      4'd4:  if (y == 0) begin t = 64'hFFFF_FFFF; r2 = x; end
             else begin t = 64'(sx / sy); r2 = 32'(sx % sy); end
      4'd5:  t = 64'(ux + uy);
      4'd6:  t = 64'(ux - uy);
      4'd7:  t = {32'd0, x & y};
      4'd8:  t = {32'd0, x | y};
      4'd9:  t = {32'd0, x ^ y};
      4'd10: t = {32'd0, ~(x | y)};
      4'd11: t = (sx < sy) ? 64'd1 : 64'd0;
      4'd12: t = (ux < uy) ? 64'd1 : 64'd0;
      default: t = 64'd0;
    endcase
    r1 = t[31:0];
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x, y, r1, r2;
  } alu_vec_t;

  alu_vec_t dir_tab[12] = '{
    '{4'd5,  32'hFFFF_FFFF, 32'h1, 32'h0,         32'h0},
    '{4'd6,  32'h0,         32'h1, 32'hFFFF_FFFF, 32'h0},
    '{4'd11, 32'hFFFF_FFFF, 32'h1, 32'h1,         32'h0},
    '{4'd12, 32'hFFFF_FFFF, 32'h1, 32'h0,         32'h0},
    '{4'd1,  32'h8000_0000, 32'h4, 32'hF800_0000, 32'h0},
    '{4'd2,  32'h8000_0000, 32'h4, 32'h0800_0000, 32'h0},
    '{4'd0,  32'h1,         32'h21, 32'h2,        32'h0},
    '{4'd3,  32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32'hFFFF_FFFF},
    '{4'd4,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF},
    '{4'd4,  32'h5,         32'h0, 32'hFFFF_FFFF, 32'h5},
    '{4'd13, 32'h1234,      32'h5678, 32'h0,      32'h0},
    '{4'd4,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0}
  };

  logic [5:0] op_tab[18]    = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                6'h23, 6'h2B, 6'h29, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h00};
  logic [5:0] funct_tab[18] = '{6'h00, 6'h03, 6'h02, 6'h04, 6'h07, 6'h06, 6'h20, 6'h21, 6'h22,
                                6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h08, 6'h0C};

  logic [31:0] pm;
  logic [31:0] e1, e2;
  logic [31:0] ri;
  ctrl_t       ec;

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    bus.pc_en = 1'b0; bus.pc_next = '0; bus.instr = '0;
    bus.alu_x = '0; bus.alu_y = '0;
    fop = 4'd0;

    #3 check("reset_pc", 64'(bus.pc), 64'h0);
    @(posedge clk); #1 rst_n = 1'b1; bus.pc_next = 32'h40; bus.pc_en = 1'b1;
    @(negedge clk); #1 check("load_40", 64'(bus.pc), 64'h40);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check("async_reset", 64'(bus.pc), 64'h0);
    @(negedge clk); #1 check("reset_holds", 64'(bus.pc), 64'h0);
    @(posedge clk); #2 rst_n = 1'b1; bus.pc_next = 32'h4;
    @(negedge clk); #1 check("load_4_fall", 64'(bus.pc), 64'h4);
    @(posedge clk); #1 check("load_4_rise", 64'(bus.pc), 64'h4);
    bus.pc_en = 1'b0; bus.pc_next = 32'h8;
    @(negedge clk); #1 check("hold_e1", 64'(bus.pc), 64'h4);
    @(posedge clk); #1 check("hold_e2", 64'(bus.pc), 64'h4);
    @(negedge clk); #1 check("hold_e3", 64'(bus.pc), 64'h4);
    pm = 32'h4;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      bus.pc_next = $urandom;
      bus.pc_en   = 1'($urandom_range(0, 1));
      if (bus.pc_en) pm = bus.pc_next;
      @(negedge clk); #1 check("pc_rand", 64'(bus.pc), 64'(pm));
    end
    bus.pc_en = 1'b0;

    bus.instr = 32'h012A_4020; bus.alu_x = 32'hFFFF_FFFF; bus.alu_y = 32'h1;
    #1 check("add_dec_r1", 64'(bus.alu_r1), 64'h0);

    force bus.aluop = fop;
    foreach (dir_tab[k]) begin
      fop = dir_tab[k].op; bus.alu_x = dir_tab[k].x; bus.alu_y = dir_tab[k].y;
      #1;
      check($sformatf("alu_dir%0d_r1", k), 64'(bus.alu_r1), 64'(dir_tab[k].r1));
      check($sformatf("alu_dir%0d_r2", k), 64'(bus.alu_r2), 64'(dir_tab[k].r2));
    end
    bus.alu_x = 32'h7; bus.alu_y = 32'h7;
    #1 check("eq_equal", 64'(bus.alu_eq), 64'h1);
    bus.alu_y = 32'h6;
    #1 check("eq_diff", 64'(bus.alu_eq), 64'h0);
    for (int k = 0; k < 300; k++) begin
      fop = 4'($urandom_range(0, 15));
      bus.alu_x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      bus.alu_y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 9) == 0) bus.alu_y = bus.alu_x;
      #1;
      alu_model(fop, bus.alu_x, bus.alu_y, e1, e2);
      check($sformatf("alu_op%0d_r1", fop), 64'(bus.alu_r1), 64'(e1));
      check($sformatf("alu_op%0d_r2", fop), 64'(bus.alu_r2), 64'(e2));
      check("alu_eq", 64'(bus.alu_eq), 64'(bus.alu_x == bus.alu_y));
    end
    release bus.aluop;

    bus.instr = 32'h012A_4020;
    #1 check("dec_add", 64'(observed_ctrl()), 64'({2'b11, 14'b0, 4'd5}));
    bus.instr = 32'h012A_4007;
    #1 check("dec_srav_shift", 64'({bus.shift, bus.shift_var, bus.aluop}), 64'({2'b11, 4'd1}));
    bus.instr = 32'h03E0_0008;
    #1 check("dec_jr", 64'({bus.jump_reg, bus.reg_we}), 64'b10);
    bus.instr = 32'h0000_000C;
    #1 check("dec_syscall", 64'({bus.sys, bus.reg_we}), 64'b10);
    bus.instr = 32'h8C88_0004;
    #1 check("dec_lw", 64'({bus.alu_src, bus.mem_to_reg, bus.reg_we}), 64'b111);
    bus.instr = 32'hAC88_0004;
    #1 check("dec_sw", 64'({bus.mem_we, bus.reg_we}), 64'b10);
    bus.instr = 32'h3488_00FF;
    #1 check("dec_ori", 64'({bus.usign, bus.aluop}), 64'({1'b1, 4'd8}));
    bus.instr = 32'h3C08_1234;
    #1 check("dec_lui", 64'(bus.load_imm), 64'h1);
    bus.instr = 32'h1509_FFFE;
    #1 check("dec_bne", 64'({bus.branch, bus.equ}), 64'b10);
    bus.instr = 32'h0C00_0010;
    #1 check("dec_jal", 64'({bus.jump, bus.jal, bus.reg_we}), 64'b111);
    bus.instr = 32'hFC00_0000;
    #1 check("dec_op3f", 64'(observed_ctrl()), 64'({16'b0, 4'd5}));

    for (int k = 0; k < 300; k++) begin
      ri = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        ri[31:26] = op_tab[$urandom_range(0, 17)];
        ri[5:0]   = funct_tab[$urandom_range(0, 17)];
      end
      bus.instr = ri;
      #1;
      ec = expect_ctrl(mnem(ri));
      check({"dec_", mnem(ri)}, 64'(observed_ctrl()), 64'(ec));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
